// File: rtl/dmem_responder.sv
// Data-memory responder: one word request at a time over valid/ready.
// The array access happens LATENCY cycles after the request is accepted. The response is held until the requester takes it.
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
`ifndef SYNTHESIS
  ,
  output logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] debug_mem_o
`endif
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];

  logic                    w_enter_resp;
  logic                    w_op_we;
  logic [ADDR_WIDTH-1:0]   w_op_addr;
  logic [DATA_WIDTH-1:0]   w_op_wdata;
  logic [ADDR_WIDTH-3:0]   w_idx_full;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_ok;

  // RESP can only be entered straight from IDLE when LATENCY is 0, and then
  // the request fields are still on the inputs rather than in the latches.
  assign w_op_we    = (r_state == S_IDLE) ? req_we_i    : r_we;
  assign w_op_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;

  assign w_idx_full = w_op_addr[ADDR_WIDTH-1:2];
  assign w_idx      = w_op_addr[IDX_W+1:2];
  assign w_ok       = (w_op_addr[1:0] == 2'b00) &&
                      (w_idx_full < (ADDR_WIDTH-2)'(MEM_SIZE));

  assign w_enter_resp = (r_state != S_RESP) && (w_state_next == S_RESP);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == '0) w_state_next = S_RESP;
      S_RESP: if (rsp_ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o = (r_state == S_IDLE);
    rsp_valid_o = (r_state == S_RESP);
  end

  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_valid_i) begin
        r_we    <= req_we_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_enter_resp) begin
        r_err   <= !w_ok;
        r_rdata <= (!w_op_we && w_ok) ? r_mem[w_idx] : '0;
      end else if (rsp_valid_o && rsp_ready_i) begin
        r_err <= 1'b0;
      end
    end
  end

  // The array must clear on reset, so it is built from flops rather than block RAM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enter_resp && w_op_we && w_ok) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

`ifndef SYNTHESIS
  generate
    for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_dbg
      assign debug_mem_o[gi] = r_mem[gi];
    end
  endgenerate
`endif

endmodule
